// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state
// encodings, default configuration and a configuration legality check.
`timescale 1ns/1ps
package uart_rx_param_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  // True when the receiver configuration lies in the supported range.
  function automatic bit cfg_ok(input int data_bits, input int oversample,
                                input int parity_en, input int parity_odd,
                                input int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 8) && ((oversample % 2) == 0) &&
           ((parity_en == 0) || (parity_en == 1)) &&
           ((parity_odd == 0) || (parity_odd == 1)) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// selectable reset value so an idle-high line reads as idle out of reset.
`timescale 1ns/1ps
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first one a full cycle to resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable word length, oversampling,
// parity and stop bits, with false-start rejection and break detection.
// Each completed frame is presented for one clock on data_ready together
// with its parity / framing / break flags.
`timescale 1ns/1ps
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  if (!cfg_ok(DATA_BITS, OVERSAMPLE, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_cfg_bad
    $error("uart_rx_param: unsupported configuration");
  end

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_50MHz),
    .rst_i (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q,  tick_d;
  logic [BW-1:0]        nbits_q, nbits_d;
  logic                 stop_q,  stop_d;
  logic [DATA_BITS-1:0] sh_q,    sh_d;
  logic                 perr_q,  perr_d;   // parity result of current frame
  logic                 ferr_q,  ferr_d;   // any stop bit seen low so far
  logic                 brk_q,   brk_d;    // every bit sampled so far was 0
  logic [DATA_BITS-1:0] dout_q,  dout_d;
  logic                 rdy_q,   rdy_d;
  logic                 pe_q,    pe_d;
  logic                 fe_q,    fe_d;
  logic                 bd_q,    bd_d;
  logic                 brk_now, ferr_now;

  // Next-state logic: counters only move on sample_tick, and each bit is
  // sampled when the tick counter reaches its mid-bit value.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    nbits_d  = nbits_q;
    stop_d   = stop_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    brk_d    = brk_q;
    dout_d   = dout_q;
    rdy_d    = 1'b0;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    bd_d     = 1'b0;
    brk_now  = brk_q;
    ferr_now = ferr_q;
    case (state_q)
      S_IDLE: begin
        // A tick coinciding with the falling edge is deliberately not counted.
        if (!rx_s) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (tick_q == TICK_HALF) begin
            if (!rx_s) begin
              state_d = S_DATA;
              tick_d  = '0;
              nbits_d = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              brk_d   = 1'b1;
            end else begin
              state_d = S_IDLE;           // glitch, not a real start bit
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            sh_d    = {rx_s, sh_q[DATA_BITS-1:1]};
            brk_d   = brk_q & ~rx_s;
            nbits_d = nbits_q + 1'b1;
            if (nbits_q == BIT_LAST) begin
              stop_d  = 1'b0;
              state_d = HAS_PAR ? S_PARITY : S_STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            perr_d  = (^{sh_q, rx_s}) ^ PAR_ODD;
            brk_d   = brk_q & ~rx_s;
            stop_d  = 1'b0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            // Break only considers the first stop bit.
            brk_now  = (stop_q == 1'b0) ? (brk_q & ~rx_s) : brk_q;
            ferr_now = ferr_q | ~rx_s;
            brk_d    = brk_now;
            ferr_d   = ferr_now;
            if (stop_q == STOP_LAST) begin
              dout_d  = sh_q;
              rdy_d   = 1'b1;
              pe_d    = perr_q;
              fe_d    = ferr_now;
              bd_d    = brk_now;
              state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
            end else begin
              stop_d = stop_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A line held low must return high before a new start is accepted.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      nbits_q <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      nbits_q <= nbits_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bd_q    <= bd_d;
    end
  end

  assign data_out   = dout_q;
  assign data_ready = rdy_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign break_det  = bd_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1, 8E1, 9N2)
// share clock, reset and baud tick; each has its own serial line.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int TICK_DIV = 27;
  localparam int OS       = 16;
  localparam int BIT_CLKS = TICK_DIV * OS;

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
    logic       b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  int   tick_cnt = 0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] dout_a, dout_b;
  logic [8:0] dout_c;
  logic rdy_a, pe_a, fe_a, bd_a;
  logic rdy_b, pe_b, fe_b, bd_b;
  logic rdy_c, pe_c, fe_c, bd_c;

  exp_t qa[$], qb[$], qc[$];
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt    <= (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    sample_tick <= (tick_cnt == TICK_DIV - 2);
  end

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk_50MHz(clk), .reset(rst), .rx(rx_a), .sample_tick(sample_tick),
    .data_out(dout_a), .data_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk_50MHz(clk), .reset(rst), .rx(rx_b), .sample_tick(sample_tick),
    .data_out(dout_b), .data_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b));

  uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
    .clk_50MHz(clk), .reset(rst), .rx(rx_c), .sample_tick(sample_tick),
    .data_out(dout_c), .data_ready(rdy_c), .parity_err(pe_c), .frame_err(fe_c), .break_det(bd_c));

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input int d, input logic rdy, input logic [8:0] dout,
                     input logic p, input logic f, input logic b);
    exp_t e;
    int   n;
    checks++;
    if (!rdy) begin
      if (p | f | b) begin
        errors++;
        $display("FAIL flags_idle dut%0d: got p=%0b f=%0b b=%0b, want all 0", d, p, f, b);
      end
      return;
    end
    case (d)
      0: n = qa.size();
      1: n = qb.size();
      default: n = qc.size();
    endcase
    if (n == 0) begin
      errors++;
      $display("FAIL unexpected_ready dut%0d: got data=%h p=%0b f=%0b b=%0b, want no output", d, dout, p, f, b);
      return;
    end
    case (d)
      0: e = qa.pop_front();
      1: e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    if ({dout, p, f, b} !== {e.d, e.p, e.f, e.b}) begin
      errors++;
      $display("FAIL frame dut%0d: got data=%h p=%0b f=%0b b=%0b, want data=%h p=%0b f=%0b b=%0b",
               d, dout, p, f, b, e.d, e.p, e.f, e.b);
    end
  endtask

  always @(negedge clk) begin
    chk(0, rdy_a, {1'b0, dout_a}, pe_a, fe_a, bd_a);
    chk(1, rdy_b, {1'b0, dout_b}, pe_b, fe_b, bd_b);
    chk(2, rdy_c, dout_c, pe_c, fe_c, bd_c);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int d, input logic v);
    case (d)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BIT_CLKS) @(negedge clk);
  endtask

  // Sends bits[0..n-1] LSB first, one bit time each; the line is left at the last bit.
  task automatic send(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(d, bits[i]);
      repeat (BIT_CLKS - 1) @(negedge clk);
    end
  endtask

  function automatic logic [15:0] fr8(input logic [7:0] dv, input logic stp);
    return {6'h3f, stp, dv, 1'b0};
  endfunction

  function automatic logic [15:0] fr8p(input logic [7:0] dv, input logic par, input logic stp);
    return {5'h1f, stp, par, dv, 1'b0};
  endfunction

  function automatic logic [15:0] fr9s2(input logic [8:0] dv);
    return {4'hf, 2'b11, dv, 1'b0};
  endfunction

  function automatic exp_t mk(input logic [8:0] dv, input logic p, input logic f, input logic b);
    exp_t e;
    e.d = dv; e.p = p; e.f = f; e.b = b;
    return e;
  endfunction

  task automatic chk_zero(input string nm);
    checks++;
    if ({rdy_a, dout_a, pe_a, fe_a, bd_a, rdy_b, dout_b, pe_b, fe_b, bd_b,
         rdy_c, dout_c, pe_c, fe_c, bd_c} !== '0) begin
      errors++;
      $display("FAIL %s: got a=%h b=%h c=%h rdy=%b%b%b, want all outputs 0",
               nm, dout_a, dout_b, dout_c, rdy_a, rdy_b, rdy_c);
    end
  endtask

  task automatic chk_drained(input string nm);
    checks++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      errors++;
      $display("FAIL %s: got pending a=%0d b=%0d c=%0d, want 0 missing frames",
               nm, qa.size(), qb.size(), qc.size());
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (5) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    idle(2);

    // 1: plain 8N1 frame
    qa.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
    send(0, fr8(8'hA5, 1'b1), 10);
    idle(2);

    // 2: 4-tick glitch rejected, then a good frame
    drive(0, 1'b0);
    repeat (4 * TICK_DIV) @(negedge clk);
    drive(0, 1'b1);
    idle(3);
    qa.push_back(mk(9'h03C, 1'b0, 1'b0, 1'b0));
    send(0, fr8(8'h3C, 1'b1), 10);
    idle(2);

    // 3: even parity, wrong then correct parity bit
    qb.push_back(mk(9'h003, 1'b1, 1'b0, 1'b0));
    send(1, fr8p(8'h03, 1'b1, 1'b1), 11);
    idle(2);
    qb.push_back(mk(9'h003, 1'b0, 1'b0, 1'b0));
    send(1, fr8p(8'h03, 1'b0, 1'b1), 11);
    idle(2);
    qb.push_back(mk(9'h0B7, 1'b1, 1'b0, 1'b0));
    send(1, fr8p(8'hB7, 1'b1, 1'b1), 11);
    idle(2);

    // 4: stop bit 0, line held low a while, then recovery
    qa.push_back(mk(9'h055, 1'b0, 1'b1, 1'b0));
    send(0, fr8(8'h55, 1'b0), 10);
    idle(3);
    drive(0, 1'b1);
    idle(2);
    chk_drained("after_frame_err");
    qa.push_back(mk(9'h00F, 1'b0, 1'b0, 1'b0));
    send(0, fr8(8'h0F, 1'b1), 10);
    idle(2);

    // 5: break, held low 20 bit-times
    qa.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
    drive(0, 1'b0);
    idle(20);
    drive(0, 1'b1);
    idle(2);
    chk_drained("after_break");
    qa.push_back(mk(9'h07E, 1'b0, 1'b0, 1'b0));
    send(0, fr8(8'h7E, 1'b1), 10);
    idle(2);

    // 6: reset in the middle of 0xF0 on the 9N2 receiver
    send(2, 16'h0000, 5);
    drive(2, 1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("after_mid_reset");
    idle(2);
    qc.push_back(mk(9'h181, 1'b0, 1'b0, 1'b0));
    send(2, fr9s2(9'h181), 12);
    idle(2);
    qc.push_back(mk(9'h100, 1'b0, 1'b0, 1'b0));
    send(2, fr9s2(9'h100), 12);
    idle(2);
    qa.push_back(mk(9'h081, 1'b0, 1'b0, 1'b0));
    send(0, fr8(8'h81, 1'b1), 10);
    idle(2);

    chk_drained("end_of_run");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
